buart_core: RTL and testbench

Baud-programmable 8N1 UART transmitter/receiver with a byte-wide register interface, used as the CPU's serial console peripheral. It runs on the single system clock, derives bit timing from a runtime `baud` value and the compile-time `CLKFREQ`, and exposes `valid`/`busy` status flags plus `rd`/`wr` strobes for the CPU I/O bus.

---
 rtl/buart_core.sv | 198 +++++++++++++++++++
 tb/tb_buart_core.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/buart_core.sv
// buart_core: baud-programmable 8N1 UART transmitter/receiver for the CPU
// serial console. Bit timing comes from a 33-bit phase accumulator per
// direction (add baud each clock, subtract CLKFREQ on overflow), so the
// average bit period is CLKFREQ/baud clocks with at most 1 clock of jitter.
//
// Ports:
//   clk      system clock, rising edge
//   resetq   asynchronous reset, active high
//   baud     bit rate in bits/s (1 .. CLKFREQ/4), held stable during a frame
//   rx       serial input, asynchronous, idle high
//   tx       serial output, idle high
//   wr       one-cycle strobe: start sending tx_data (ignored while busy)
//   tx_data  byte to send, sampled with wr
//   busy     transmitter occupied
//   rd       one-cycle strobe: clear valid
//   valid    a received byte is waiting in rx_data
//   rx_data  last correctly framed received byte
module buart_core #(
    parameter int unsigned CLKFREQ = 12_000_000
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] baud,
    input  logic        rx,
    output logic        tx,
    input  logic        wr,
    input  logic [7:0]  tx_data,
    output logic        busy,
    input  logic        rd,
    output logic        valid,
    output logic [7:0]  rx_data
);

    localparam int unsigned ACC_W = 33;
    localparam logic [ACC_W-1:0] CLK_ACC  = ACC_W'(CLKFREQ);
    localparam logic [ACC_W-1:0] HALF_ACC = ACC_W'(CLKFREQ / 2);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

    tx_state_t        tx_state;
    logic [ACC_W-1:0] tx_acc;
    logic [ACC_W-1:0] tx_sum_c;
    logic             tx_tick_c;
    logic [8:0]       tx_shreg;   // stop bit + data bits still to go out
    logic [3:0]       tx_cnt;     // bit ticks seen in this frame

    // TX bit-tick generation
    always_comb begin
        tx_sum_c  = tx_acc + ACC_W'(baud);
        tx_tick_c = (tx_sum_c >= CLK_ACC);
    end

    // TX FSM: start bit goes out directly on wr, the other nine bits shift
    // out on ticks, and the tenth tick ends the stop bit.
    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            tx_state <= TX_IDLE;
            tx_acc   <= '0;
            tx_shreg <= '1;
            tx_cnt   <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (wr) begin
                        tx_shreg <= {1'b1, tx_data};
                        tx_acc   <= '0;
                        tx_cnt   <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        tx_state <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    if (tx_tick_c) begin
                        tx_acc <= tx_sum_c - CLK_ACC;
                        if (tx_cnt == 4'd9) begin
                            tx       <= 1'b1;
                            busy     <= 1'b0;
                            tx_state <= TX_IDLE;
                        end else begin
                            tx       <= tx_shreg[0];
                            tx_shreg <= {1'b1, tx_shreg[8:1]};
                            tx_cnt   <= tx_cnt + 4'd1;
                        end
                    end else begin
                        tx_acc <= tx_sum_c;
                    end
                end
                default: tx_state <= TX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t        rx_state;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    logic [ACC_W-1:0] rx_acc;
    logic [ACC_W-1:0] rx_sum_c;
    logic             rx_tick_c;
    logic             rx_fall_c;
    logic [7:0]       rx_shreg;
    logic [2:0]       rx_cnt;

    // Two-flop synchronizer plus one delayed copy for edge detection;
    // reset high so leaving reset never looks like a start edge.
    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    // RX bit-tick generation and start-edge detection
    always_comb begin
        rx_sum_c  = rx_acc + ACC_W'(baud);
        rx_tick_c = (rx_sum_c >= CLK_ACC);
        rx_fall_c = rx_prev & ~rx_s2;
    end

    // RX FSM. The accumulator is preset to half a period on the start edge
    // so every tick lands in the middle of a bit.
    always_ff @(posedge clk or posedge resetq) begin
        if (resetq) begin
            rx_state <= RX_IDLE;
            rx_acc   <= '0;
            rx_shreg <= '0;
            rx_cnt   <= '0;
            rx_data  <= '0;
            valid    <= 1'b0;
        end else begin
            // rd clears first so a byte completing in the same cycle wins
            if (rd) begin
                valid <= 1'b0;
            end

            if (rx_state != RX_IDLE) begin
                rx_acc <= rx_tick_c ? (rx_sum_c - CLK_ACC) : rx_sum_c;
            end

            case (rx_state)
                RX_IDLE: begin
                    if (rx_fall_c) begin
                        rx_acc   <= HALF_ACC;
                        rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (rx_tick_c) begin
                        if (rx_s2) begin
                            rx_state <= RX_IDLE;   // glitch, not a start bit
                        end else begin
                            rx_cnt   <= '0;
                            rx_state <= RX_DATA;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_tick_c) begin
                        rx_shreg <= {rx_s2, rx_shreg[7:1]};
                        if (rx_cnt == 3'd7) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_cnt <= rx_cnt + 3'd1;
                        end
                    end
                end
                RX_STOP: begin
                    if (rx_tick_c) begin
                        // a low stop bit is a framing error: drop the byte
                        if (rx_s2) begin
                            rx_data <= rx_shreg;
                            valid   <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_buart_core.sv
// Directed bench for buart_core at CLKFREQ = 1 MHz.
module tb_buart_core;

    localparam int unsigned CLKFREQ = 1_000_000;

    logic        clk = 1'b0;
    logic        resetq;
    logic [31:0] baud;
    logic        rx;
    logic        rx_drv;
    logic        loop_en;
    logic        tx;
    logic        wr;
    logic [7:0]  tx_data;
    logic        busy;
    logic        rd;
    logic        valid;
    logic [7:0]  rx_data;

    int vectors     = 0;
    int miscompares = 0;

    int          cyc;
    int          b;
    logic [9:0]  fr;
    int          cum300 [10] = '{4, 7, 10, 14, 17, 20, 24, 27, 30, 34};

    always #5 clk = ~clk;

    assign rx = loop_en ? tx : rx_drv;

    buart_core #(.CLKFREQ(CLKFREQ)) dut (
        .clk     (clk),
        .resetq  (resetq),
        .baud    (baud),
        .rx      (rx),
        .tx      (tx),
        .wr      (wr),
        .tx_data (tx_data),
        .busy    (busy),
        .rd      (rd),
        .valid   (valid),
        .rx_data (rx_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one 8N1 frame on rx at 10 clocks per bit; rd pulses for one
    // cycle when the in-frame clock count equals rd_at.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int rd_at);
        logic [9:0] bits;
        int n;
        bits = {stop_bit, d, 1'b0};
        n = 0;
        for (int i = 0; i < 10; i++) begin
            rx_drv = bits[i];
            for (int j = 0; j < 10; j++) begin
                step();
                n++;
                rd = (n == rd_at);
            end
        end
        rd = 1'b0;
    endtask

    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!valid && cycles < 300) begin
            step();
            cycles++;
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            step();
            k++;
        end
        chk("tx_idle_wait", 32'(busy), 32'd0);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        resetq  = 1'b1;
        wr      = 1'b0;
        rd      = 1'b0;
        tx_data = 8'h00;
        baud    = 32'd100_000;
        rx_drv  = 1'b1;
        loop_en = 1'b0;

        // Reset state
        #12;
        chk("rst_tx",      32'(tx),      32'd1);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_valid",   32'(valid),   32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'h00);
        resetq = 1'b0;
        step();
        step();

        // 0x55 at P = 10: each bit exactly 10 clocks, busy 100 clocks
        fr = {1'b1, 8'h55, 1'b0};
        tx_data = 8'h55;
        wr = 1'b1;
        step();
        wr = 1'b0;
        for (int c = 0; c < 100; c++) begin
            chk("tx55_bit",  32'(tx),   32'(fr[c / 10]));
            chk("tx55_busy", 32'(busy), 32'd1);
            step();
        end
        chk("tx55_busy_end", 32'(busy), 32'd0);
        chk("tx55_tx_end",   32'(tx),   32'd1);

        // Loopback 0xA3: valid 98 clocks after the start edge, then rd
        loop_en = 1'b1;
        tx_data = 8'hA3;
        wr = 1'b1;
        step();
        wr = 1'b0;
        wait_valid(cyc);
        chk("lb_latency", 32'(cyc),     32'd98);
        chk("lb_valid",   32'(valid),   32'd1);
        chk("lb_rx_data", 32'(rx_data), 32'hA3);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("lb_rd_clear", 32'(valid), 32'd0);
        wait_idle();
        loop_en = 1'b0;
        repeat (5) step();

        // 3-clock glitch: no byte, then a clean 0x0F frame
        rx_drv = 1'b0;
        repeat (3) step();
        rx_drv = 1'b1;
        repeat (30) step();
        chk("glitch_valid", 32'(valid), 32'd0);
        send_frame(8'h0F, 1'b1, -1);
        chk("f0f_valid",   32'(valid),   32'd1);
        chk("f0f_rx_data", 32'(rx_data), 32'h0F);
        rd = 1'b1;
        step();
        rd = 1'b0;
        chk("f0f_rd_clear", 32'(valid), 32'd0);

        // Framing error on 0x81: byte dropped, flags untouched
        send_frame(8'h81, 1'b0, -1);
        rx_drv = 1'b1;
        repeat (20) step();
        chk("ferr_valid",   32'(valid),   32'd0);
        chk("ferr_rx_data", 32'(rx_data), 32'h0F);

        // Overrun: two frames without rd, second overwrites
        send_frame(8'h3C, 1'b1, -1);
        chk("ovr1_valid",   32'(valid),   32'd1);
        chk("ovr1_rx_data", 32'(rx_data), 32'h3C);
        send_frame(8'hC5, 1'b1, -1);
        chk("ovr2_valid",   32'(valid),   32'd1);
        chk("ovr2_rx_data", 32'(rx_data), 32'hC5);

        // rd in the same cycle as byte completion: new byte wins
        send_frame(8'h6E, 1'b1, 97);
        chk("rdcoll_valid",   32'(valid),   32'd1);
        chk("rdcoll_rx_data", 32'(rx_data), 32'h6E);
        repeat (5) step();

        // Asynchronous reset in the middle of a transmit (0x12, data bit0 = 0)
        tx_data = 8'h12;
        wr = 1'b1;
        step();
        wr = 1'b0;
        repeat (14) step();
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_tx",   32'(tx),   32'd0);
        #2;
        resetq = 1'b1;
        #1;
        chk("arst_tx",      32'(tx),      32'd1);
        chk("arst_busy",    32'(busy),    32'd0);
        chk("arst_valid",   32'(valid),   32'd0);
        chk("arst_rx_data", 32'(rx_data), 32'h00);
        #3;
        resetq = 1'b0;
        repeat (3) step();

        // baud 300k: 0xFF, second wr while busy must be ignored; frame 34 clocks
        baud = 32'd300_000;
        step();
        tx_data = 8'hFF;
        wr = 1'b1;
        step();
        wr = 1'b0;
        for (int c = 0; c < 34; c++) begin
            chk("ff_tx",   32'(tx),   (c < 4) ? 32'd0 : 32'd1);
            chk("ff_busy", 32'(busy), 32'd1);
            if (c == 3) begin
                tx_data = 8'h00;
                wr = 1'b1;
            end else begin
                wr = 1'b0;
            end
            step();
        end
        wr = 1'b0;
        chk("ff_busy_end", 32'(busy), 32'd0);
        chk("ff_tx_end",   32'(tx),   32'd1);
        repeat (3) step();

        // baud 300k with 0x55: bit lengths 4,3,3,4,3,3,4,3,3,4
        fr = {1'b1, 8'h55, 1'b0};
        tx_data = 8'h55;
        wr = 1'b1;
        step();
        wr = 1'b0;
        b = 0;
        for (int c = 0; c < 34; c++) begin
            while (b < 9 && c >= cum300[b]) b++;
            chk("p333_tx",   32'(tx),   32'(fr[b]));
            chk("p333_busy", 32'(busy), 32'd1);
            step();
        end
        chk("p333_busy_end", 32'(busy), 32'd0);
        chk("p333_tx_end",   32'(tx),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
